// File: rtl/data_sram_responder.sv
// data_sram_responder: in-order SRAM-like data responder with fixed latency and bounded outstanding queue
module data_sram_responder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        addr_stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [CW-1:0] cnt_q [DEPTH];
  logic [CW-1:0] cnt_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [ADDR_W-1:0] idx;
  logic accept, retire, unused;
  assign idx = data_sram_addr[ADDR_W+1:2];
  assign unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
  always_comb begin
    retire = occ_q != '0 && cnt_q[head_q] == '0;
    data_sram_data_ok = retire;
    data_sram_rdata = retire ? data_q[head_q] : '0;
    data_sram_addr_ok = !addr_stall && (occ_q < OW'(DEPTH) || retire);
    accept = data_sram_req && data_sram_addr_ok;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d[k] = cnt_q[k] == '0 ? '0 : cnt_q[k] - 1'b1;
      data_d[k] = data_q[k];
    end
    if (accept) begin
      cnt_d[tail_q] = CW'(LATENCY - 1);
      data_d[tail_q] = mem[idx];
    end
    head_d = retire ? (head_q == PW'(DEPTH - 1) ? '0 : head_q + 1'b1) : head_q;
    tail_d = accept ? (tail_q == PW'(DEPTH - 1) ? '0 : tail_q + 1'b1) : tail_q;
    occ_d = occ_q + OW'(accept) - OW'(retire);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) cnt_q[k] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (accept && data_sram_wr)
      for (int b = 0; b < 4; b++)
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized and directed checks against a timestamped in-order response model
module tb_data_sram_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 2;
  localparam int LATENCY = 3;
  logic clk = 0;
  logic resetn = 0;
  logic req = 0, wr = 0, stall = 0;
  logic [1:0] size = 2;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic aok, dok;
  logic [31:0] rdata;
  data_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .addr_stall(stall), .data_sram_addr_ok(aok),
    .data_sram_data_ok(dok), .data_sram_rdata(rdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic known; logic w; int due;} ent_t;
  typedef struct {logic r; logic w; logic [3:0] s; logic [31:0] a; logic [31:0] d; logic st;} stim_t;
  ent_t q[$];
  logic [31:0] mm [int];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic exp_aok, exp_dok, exp_care;
  logic [31:0] exp_rd;
  function automatic stim_t mk(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d, logic st);
    stim_t t;
    t.r = r; t.w = w; t.s = s; t.a = a; t.d = d; t.st = st;
    return t;
  endfunction
  function void model_outputs();
    exp_dok = q.size() > 0 && q[0].due <= cyc;
    exp_aok = !stall && (q.size() < DEPTH || exp_dok);
    exp_rd = 0;
    exp_care = 1;
    if (exp_dok) begin
      exp_rd = q[0].d;
      exp_care = !q[0].w && q[0].known;
    end
  endfunction
  task automatic step(input stim_t t);
    req = t.r; wr = t.w; wstrb = t.s; addr = t.a; wdata = t.d; stall = t.st;
    @(negedge clk);
    model_outputs();
  endtask
  task automatic advance();
    int i;
    ent_t e;
    logic [31:0] v;
    model_outputs();
    @(posedge clk);
    if (exp_dok) void'(q.pop_front());
    if (req && exp_aok) begin
      i = int'(addr[ADDR_W+1:2]);
      e.w = wr;
      e.known = mm.exists(i);
      e.d = e.known ? mm[i] : 32'h0;
      e.due = cyc + LATENCY;
      q.push_back(e);
      if (wr && wstrb == 4'hF) mm[i] = wdata;
      else if (wr && mm.exists(i)) begin
        v = mm[i];
        for (int b = 0; b < 4; b++) if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
        mm[i] = v;
      end
    end
    cyc++;
    #1;
  endtask
  task automatic test_reset();
    req = 0; stall = 0;
    #2;
    vectors++;
    if ({aok, dok, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_idle got aok=%b dok=%b rdata=%h exp 1/0/0", aok, dok, rdata);
    end
    stall = 1;
    #1;
    vectors++;
    if (aok !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got aok=%b exp 0", aok);
    end
    stall = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    q.delete();
  endtask
  task automatic test_word_rw();
    stim_t s[$];
    logic [31:0] got[$];
    int dc[$];
    int c0, j, n;
    s.push_back(mk(1, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h40, 32'h0, 0));
    repeat (6) s.push_back(mk(0, 0, 0, 0, 0, 0));
    c0 = cyc; j = 0;
    for (n = 0; j < s.size() && n < 100; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL word_rw cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (dok) begin got.push_back(rdata); dc.push_back(cyc - c0); end
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size() || got.size() != 2 || dc[0] != LATENCY || dc[1] != LATENCY + 1 || got[1] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_rw_timing got pulses=%0d at %0d,%0d rdata=%h exp 2 at %0d,%0d rdata=deadbeef",
               got.size(), dc[0], dc[1], got[1], LATENCY, LATENCY + 1);
    end
  endtask
  task automatic test_strobes();
    stim_t s[$];
    logic [31:0] got[$];
    int j, n;
    s.push_back(mk(1, 1, 4'hF, 32'h80, 32'h11223344, 0));
    s.push_back(mk(1, 1, 4'h2, 32'h80, 32'h0000AA00, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h80, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h83, 32'h0, 0));
    s.push_back(mk(1, 1, 4'h0, 32'h80, 32'hFFFFFFFF, 0));
    s.push_back(mk(1, 0, 4'h0, 32'hABC00080, 32'h0, 0));
    repeat (8) s.push_back(mk(0, 0, 0, 0, 0, 0));
    j = 0;
    for (n = 0; j < s.size() && n < 100; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL strobes cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (dok && exp_dok && !q[0].w) got.push_back(rdata);
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size() || got.size() != 3 || got[0] !== 32'h1122AA44 || got[1] !== 32'h1122AA44 || got[2] !== 32'h1122AA44) begin
      miscompares++;
      $display("FAIL strobes_data got n=%0d %h %h %h exp 3x 1122aa44", got.size(), got[0], got[1], got[2]);
    end
  endtask
  task automatic test_back_pressure();
    stim_t s[$];
    int acc[$];
    int dc[$];
    int c0, j, n;
    repeat (3) s.push_back(mk(1, 0, 4'h0, 32'h40, 32'h0, 0));
    repeat (2) s.push_back(mk(0, 0, 0, 0, 0, 1));
    repeat (6) s.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (2) s.push_back(mk(0, 0, 0, 0, 0, 1));
    c0 = cyc; j = 0;
    for (n = 0; j < s.size() && n < 100; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL back_pressure cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (s[j].st) begin
        vectors++;
        if (aok !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_forces_low cyc=%0d got aok=%b exp 0", cyc, aok);
        end
      end
      if (req && aok) acc.push_back(cyc - c0);
      if (dok) dc.push_back(cyc - c0);
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size() || acc.size() != 3 || acc[0] != 0 || acc[1] != 1 || acc[2] != LATENCY || dc.size() != 3 || dc[0] != LATENCY) begin
      miscompares++;
      $display("FAIL back_pressure_accepts got accepts=%0d at %0d,%0d,%0d first_ok=%0d exp 3 at 0,1,%0d first_ok=%0d",
               acc.size(), acc[0], acc[1], acc[2], dc[0], LATENCY, LATENCY);
    end
  endtask
  task automatic test_ordering();
    stim_t s[$];
    logic [31:0] got[$];
    logic [31:0] want[$];
    int j, n;
    bit bad;
    for (int w = 0; w < 4; w++) s.push_back(mk(1, 1, 4'hF, 32'(w * 4), 32'(w), 0));
    s.push_back(mk(1, 1, 4'hF, 32'h14, 32'h55, 0));
    for (int w = 0; w < 4; w++) s.push_back(mk(1, 0, 4'h0, 32'(w * 4), 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h14, 32'h0, 0));
    s.push_back(mk(1, 1, 4'hF, 32'h14, 32'h66, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h14, 32'h0, 0));
    repeat (8) s.push_back(mk(0, 0, 0, 0, 0, 0));
    want = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h55, 32'h66};
    j = 0;
    for (n = 0; j < s.size() && n < 200; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL ordering cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (dok && exp_dok && !q[0].w) got.push_back(rdata);
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    bad = j != s.size() || got.size() != want.size();
    for (int i = 0; i < want.size() && !bad; i++) if (got[i] !== want[i]) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL ordering_data got n=%0d first=%h last=%h exp 0,1,2,3,55,66", got.size(), got[0], got[got.size()-1]);
    end
  endtask
  task automatic test_random();
    stim_t s[$];
    logic [31:0] r;
    int j, n;
    for (int w = 0; w < 16; w++) s.push_back(mk(1, 1, 4'hF, 32'(w * 4), $urandom(), 0));
    repeat (300) begin
      r = $urandom();
      s.push_back(mk($urandom_range(9, 0) < 7, r[0], 4'($urandom()),
                     {r[31:12], 6'b0, 4'($urandom_range(15, 0)), r[1:0]}, $urandom(), $urandom_range(4, 0) == 0));
    end
    repeat (8) s.push_back(mk(0, 0, 0, 0, 0, 0));
    j = 0;
    for (n = 0; j < s.size() && n < 5000; n++) begin
      if (s[j].st && n % 7 == 0) s[j].st = 0;
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL random cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size()) begin
      miscompares++;
      $display("FAIL random_timeout got %0d of %0d applied", j, s.size());
    end
  endtask
  task automatic test_reset_mid();
    stim_t s[$];
    logic [31:0] got[$];
    int j, n;
    s.push_back(mk(1, 1, 4'hF, 32'h1C, 32'hCAFEF00D, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h1C, 32'h0, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h1C, 32'h0, 0));
    j = 0;
    for (n = 0; j < s.size() && n < 50; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL reset_mid_fill cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size() || q.size() != 2) begin
      miscompares++;
      $display("FAIL reset_mid_setup got applied=%0d outstanding=%0d exp %0d/2", j, q.size(), s.size());
    end
    req = 0; stall = 0;
    #2;
    resetn = 0;
    #1;
    vectors++;
    if ({aok, dok, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_immediate got aok=%b dok=%b rdata=%h exp 1/0/0", aok, dok, rdata);
    end
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    resetn = 1;
    s.delete();
    repeat (6) s.push_back(mk(0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 4'h0, 32'h1C, 32'h0, 0));
    repeat (6) s.push_back(mk(0, 0, 0, 0, 0, 0));
    j = 0;
    for (n = 0; j < s.size() && n < 50; n++) begin
      step(s[j]);
      vectors++;
      if ({aok, dok} !== {exp_aok, exp_dok} || (exp_care && rdata !== exp_rd)) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc, aok, dok, rdata, exp_aok, exp_dok, exp_rd);
      end
      if (dok) got.push_back(rdata);
      if (!s[j].r || exp_aok) j++;
      advance();
    end
    vectors++;
    if (j != s.size() || got.size() != 1 || got[0] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL reset_mid_ram got pulses=%0d rdata=%h exp 1 cafef00d", got.size(), got[0]);
    end
  endtask
  initial begin
    test_reset();
    test_word_rw();
    test_strobes();
    test_back_pressure();
    test_ordering();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
